oam_dma_responder: RTL
======================

OAM_DMA_RESPONDER -- requirements
Module: oam_dma_responder

Interface
REQ-001 SHALL have parameter OAM_BASE, default 16'hFE00: first OAM address.
REQ-002 SHALL have parameter OAM_SIZE, default 160: OAM bytes; valid window is OAM_BASE..OAM_BASE+OAM_SIZE-1.
REQ-003 SHALL have parameter IDLE_ADDR, default 16'hFFFF: addr_select value meaning "no request".
REQ-004 SHALL have port clk, input, 1: single system clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port cpu_req, mem_if.slave, -: CPU access port (addr_select, write_enable, write_value, read_out).
REQ-007 SHALL have port dma_req, mem_if.slave, -: OAM DMA engine port, same signals.
REQ-008 SHALL have port ppu_mode, input, 2: current PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 draw).
REQ-009 SHALL have port ppu_rd_addr, input, 8: PPU OAM byte index.
REQ-010 SHALL have port ppu_rd_data, output, 8: OAM byte for ppu_rd_addr, registered.
REQ-011 SHALL have port dma_active, output, 1: high while a DMA transfer is in progress.
REQ-012 SHALL have port dma_done, output, 1: one-cycle pulse when the last OAM byte of a transfer is written.

Function
REQ-013 SHALL store OAM in an OAM_SIZE x 8 array indexed by addr_select - OAM_BASE.
REQ-014 SHALL treat a port as requesting when its addr_select != IDLE_ADDR.
REQ-015 SHALL set dma_active in the cycle after dma_req.addr_select first leaves IDLE_ADDR, and clear it in the cycle after it returns to IDLE_ADDR.
REQ-016 SHALL commit a write once per write_enable assertion: on the first cycle write_enable is high with an OAM-window address; further high cycles at the same address SHALL NOT rewrite.
REQ-017 SHALL re-arm write commit when write_enable deasserts or addr_select changes.
REQ-018 SHALL register read_out with 1-cycle latency: value for addr_select at edge N is visible after edge N+1.
REQ-019 SHALL service DMA reads and writes in the OAM window regardless of ppu_mode.
REQ-020 SHALL give DMA priority: while dma_active, CPU writes to any address SHALL be ignored, and CPU reads SHALL return 8'hFF except FF80..FFFE, which this block does not serve.
REQ-021 SHALL, when not dma_active and ppu_mode is 2 or 3, ignore CPU OAM writes and return 8'hFF for CPU OAM reads.
REQ-022 SHALL, otherwise, perform CPU OAM reads and writes normally.
REQ-023 SHALL return 8'h00 for reads of OAM_BASE+OAM_SIZE..16'hFEFF and ignore writes there.
REQ-024 SHALL drive read_out 8'hFF for addresses outside FE00..FEFF and when idle.
REQ-025 SHALL keep an 8-bit DMA write counter: cleared when dma_active rises, incremented on each committed DMA OAM write.
REQ-026 SHALL pulse dma_done for exactly one cycle on the commit where the counter goes from OAM_SIZE-1 to OAM_SIZE.
REQ-027 SHALL saturate the counter at OAM_SIZE; extra DMA writes still commit but SHALL NOT re-pulse dma_done.
REQ-028 SHALL, if CPU and DMA write the same OAM byte in one cycle, commit only the DMA value.
REQ-029 SHALL register ppu_rd_data with 1-cycle latency from ppu_rd_addr; indices >= OAM_SIZE SHALL read 8'hFF.
REQ-030 SHALL, if DMA writes the byte the PPU reads in the same cycle, return the old value (read-before-write).

Reset
REQ-031 SHALL, on rst, clear dma_active, dma_done, counter, and write-commit arm state; set both read_out to 8'hFF and ppu_rd_data to 8'hFF.
REQ-032 SHALL NOT clear OAM contents on rst.
REQ-033 SHALL abort an in-progress transfer on rst; no dma_done SHALL follow, and the next transfer SHALL start at counter 0.

Verification
REQ-034 Full DMA: 160 single-commit writes FE00..FE9F with value = index ^ 8'h5A -> dma_done pulses once after write 160; CPU reads FE00 and FE9F after idle return 8'h5A and 8'hC5.
REQ-035 DMA blocking: CPU writes 8'h11 to FE10 while dma_active -> ignored; CPU read of FE10 returns 8'hFF; after DMA, FE10 holds the DMA value.
REQ-036 PPU lock: ppu_mode=3, CPU writes 8'h22 to FE20 -> FE20 unchanged; ppu_mode=0, same write -> CPU read returns 8'h22 one cycle later.
REQ-037 Held write_enable: DMA holds write_enable 3 cycles at FE05 -> counter +1 only; FEA0 read returns 8'h00.
REQ-038 Reset mid-DMA: rst after 80 writes -> dma_active=0, no dma_done; next full transfer pulses dma_done after exactly 160 writes.
REQ-039 Same-cycle collision: CPU (mode 0, no DMA active yet) and DMA's first write both target FE00 -> FE00 holds DMA value; PPU reading index 0 that cycle returns the prior value.

Source files
------------

// File: rtl/oam_dma_responder_if.sv
// Byte-wide memory request bus shared by the CPU and the OAM DMA engine.
// addr_select at the idle address means "no request"; read_out is driven by the responder.
interface mem_if;
   logic [15:0] addr_select;
   logic        write_enable;
   logic [7:0]  write_value;
   logic [7:0]  read_out;

   modport slave  (input addr_select, write_enable, write_value, output read_out);
   modport master (output addr_select, write_enable, write_value, input read_out);
endinterface

// File: rtl/oam_dma_responder.sv
// OAM storage arbitrated between the CPU, the OAM DMA engine and the PPU scan port.
// DMA always wins; the CPU is locked out during DMA and during PPU modes 2/3.
module oam_dma_responder #(
   parameter logic [15:0] OAM_BASE  = 16'hFE00,
   parameter int          OAM_SIZE  = 160,
   parameter logic [15:0] IDLE_ADDR = 16'hFFFF
) (
   input  logic       clk,
   input  logic       rst,
   mem_if.slave       cpu_req,
   mem_if.slave       dma_req,
   input  logic [1:0] ppu_mode,
   input  logic [7:0] ppu_rd_addr,
   output logic [7:0] ppu_rd_data,
   output logic       dma_active,
   output logic       dma_done
);
   localparam int          IW     = (OAM_SIZE > 1) ? $clog2(OAM_SIZE) : 1;
   localparam logic [15:0] SIZE16 = 16'(OAM_SIZE);
   localparam logic [7:0]  SIZE8  = 8'(OAM_SIZE);

   logic [7:0]  oam [OAM_SIZE];

   logic [15:0] cpu_off, dma_off;
   logic        cpu_in_oam, dma_in_oam, cpu_in_page, dma_in_page;
   logic        cpu_pending, dma_pending, dma_rise, cpu_locked;
   logic        cpu_fire, dma_fire, cpu_commit, dma_commit;
   logic        cpu_prev_we, dma_prev_we;
   logic [15:0] cpu_prev_addr, dma_prev_addr;
   logic [7:0]  dma_cnt, cnt_base, cpu_rd, dma_rd;

   // NOTE: every signal written here gets a default before any branch so no latch is inferred.
   always_comb begin
      cpu_off     = cpu_req.addr_select - OAM_BASE;
      dma_off     = dma_req.addr_select - OAM_BASE;
      cpu_pending = cpu_req.addr_select != IDLE_ADDR;
      dma_pending = dma_req.addr_select != IDLE_ADDR;
      // Offsets below OAM_BASE wrap to large values, so one compare bounds the window.
      cpu_in_oam  = cpu_pending && (cpu_off < SIZE16);
      dma_in_oam  = dma_pending && (dma_off < SIZE16);
      cpu_in_page = cpu_pending && (cpu_req.addr_select[15:8] == 8'hFE);
      dma_in_page = dma_pending && (dma_req.addr_select[15:8] == 8'hFE);

      // A write fires once per write_enable assertion at a given address.
      cpu_fire = cpu_req.write_enable &&
                 (!cpu_prev_we || (cpu_req.addr_select != cpu_prev_addr));
      dma_fire = dma_req.write_enable &&
                 (!dma_prev_we || (dma_req.addr_select != dma_prev_addr));

      cpu_locked = dma_active || (ppu_mode == 2'd2) || (ppu_mode == 2'd3);
      cpu_commit = cpu_fire && cpu_in_oam && !cpu_locked && !rst;
      dma_commit = dma_fire && dma_in_oam && !rst;

      dma_rise = dma_pending && !dma_active;
      cnt_base = dma_rise ? 8'd0 : dma_cnt;

      dma_rd = 8'hFF;
      if (dma_in_oam)
         dma_rd = oam[dma_off[IW-1:0]];
      else if (dma_in_page)
         dma_rd = 8'h00;

      cpu_rd = 8'hFF;
      if (!dma_active) begin
         if (cpu_in_oam && !cpu_locked)
            cpu_rd = oam[cpu_off[IW-1:0]];
         else if (cpu_in_page && !cpu_in_oam)
            cpu_rd = 8'h00;
      end
   end

   // NOTE: the OAM array has no reset; its contents survive rst, and leaving it unreset keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (cpu_commit)
         oam[cpu_off[IW-1:0]] <= cpu_req.write_value;
      if (dma_commit)
         oam[dma_off[IW-1:0]] <= dma_req.write_value;  // last assignment wins a same-byte collision
   end

   // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         dma_active       <= 1'b0;
         dma_done         <= 1'b0;
         dma_cnt          <= 8'd0;
         cpu_prev_we      <= 1'b0;
         dma_prev_we      <= 1'b0;
         cpu_prev_addr    <= IDLE_ADDR;
         dma_prev_addr    <= IDLE_ADDR;
         cpu_req.read_out <= 8'hFF;
         dma_req.read_out <= 8'hFF;
         ppu_rd_data      <= 8'hFF;
      end else begin
         dma_active       <= dma_pending;
         dma_done         <= 1'b0;
         cpu_prev_we      <= cpu_req.write_enable;
         dma_prev_we      <= dma_req.write_enable;
         cpu_prev_addr    <= cpu_req.addr_select;
         dma_prev_addr    <= dma_req.addr_select;
         cpu_req.read_out <= cpu_rd;
         dma_req.read_out <= dma_rd;
         ppu_rd_data      <= ({8'h00, ppu_rd_addr} < SIZE16) ? oam[ppu_rd_addr[IW-1:0]] : 8'hFF;

         if (dma_rise)
            dma_cnt <= 8'd0;
         // Counter saturates at OAM_SIZE; done pulses only on the final step into it.
         if (dma_commit && (cnt_base != SIZE8)) begin
            dma_cnt  <= cnt_base + 8'd1;
            dma_done <= (cnt_base == SIZE8 - 8'd1);
         end
      end
   end
endmodule
